// File: rtl/mcpu_param_core.sv
`default_nettype none
// ============================================================================
// Module      : mcpu_param_core
// Description : Parameterised accumulator micro-CPU with 6-bit instructions
//               fed directly on inst_in, one instruction per clock.
//               cpu_out shows pc while clk=1 and out_reg while clk=0.
//               Optional feature macro: MCPU_LINK_EN (JSR/RET link register;
//               when undefined, JSR and RET execute as NOP).
// Revision    : 1.0 - initial release
// ============================================================================
module mcpu_param_core #(
  parameter int DATA_W    = 8,
  parameter int PC_W      = 6,
  parameter int REG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        inst_in,
  output logic [DATA_W-1:0] cpu_out
);

  // Architectural state
  logic [DATA_W-1:0] accu_q, accu_d;
  logic              carry_q, carry_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              iflag_q, iflag_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] regs_q [REG_DEPTH];
  logic [DATA_W-1:0] regs_d [REG_DEPTH];
`ifdef MCPU_LINK_EN
  logic [PC_W-1:0]   link_q, link_d;
`endif

  // Decode helpers
  logic [3:0]        w_imm;
  logic [2:0]        w_ridx;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_imm_pc;
  logic [DATA_W-1:0] w_imm_data;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W:0]   w_sum;
  logic              w_sta_en;

  // Read table padded to the full 3-bit register address space; missing entries read 0
  logic [DATA_W-1:0] w_rd_tbl [8];

  generate
    for (genvar g = 0; g < 8; g++) begin : g_rd
      if (g < REG_DEPTH) begin : g_hit
        assign w_rd_tbl[g] = regs_q[g];
      end else begin : g_miss
        assign w_rd_tbl[g] = '0;
      end
    end
  endgenerate

  assign w_imm      = inst_in[3:0];
  assign w_ridx     = inst_in[2:0];
  assign w_pc_inc   = pc_q + PC_W'(1);
  assign w_imm_pc   = {{(PC_W-4){w_imm[3]}}, w_imm};
  assign w_imm_data = {{(DATA_W-4){w_imm[3]}}, w_imm};
  assign w_rd_data  = w_rd_tbl[w_ridx];
  assign w_sum      = {1'b0, accu_q} + {1'b0, w_rd_data};

  // Clock-phase multiplexed output; all state is zero during reset so this reads 0 then
  assign cpu_out = clk ? DATA_W'(pc_q) : out_q;

  // Instruction decode and next-state computation
  always_comb begin
    accu_d   = accu_q;
    carry_d  = carry_q;
    pc_d     = w_pc_inc;
    iflag_d  = 1'b0;
    out_d    = out_q;
    w_sta_en = 1'b0;
`ifdef MCPU_LINK_EN
    link_d   = link_q;
`endif
    casez (inst_in)
      6'b00????: begin
        pc_d    = carry_q ? w_pc_inc : (pc_q + w_imm_pc);
        carry_d = 1'b0;
      end
      6'b01????: begin
        accu_d  = iflag_q ? {accu_q[DATA_W-5:0], w_imm} : w_imm_data;
        iflag_d = 1'b1;
      end
      6'b100???: {carry_d, accu_d} = w_sum;
      6'b101???: w_sta_en = 1'b1;
      6'b110???: accu_d = w_rd_data;
      6'b111000: accu_d = ~accu_q;
      6'b111001: out_d = accu_q;
      6'b111010: pc_d = accu_q[PC_W-1:0];
`ifdef MCPU_LINK_EN
      6'b111011: begin
        link_d = w_pc_inc;
        pc_d   = accu_q[PC_W-1:0];
      end
      6'b111100: pc_d = link_q;
`endif
      6'b111101: {accu_d, carry_d} = {carry_q, accu_q};
      default: ;
    endcase
  end

  // Register file write port; indices beyond REG_DEPTH match no entry
  always_comb begin
    for (int i = 0; i < REG_DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (w_sta_en && (w_ridx == 3'(i))) begin
        regs_d[i] = accu_q;
      end
    end
  end

  // State update with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      accu_q  <= '0;
      carry_q <= 1'b0;
      pc_q    <= '0;
      iflag_q <= 1'b0;
      out_q   <= '0;
`ifdef MCPU_LINK_EN
      link_q  <= '0;
`endif
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      accu_q  <= accu_d;
      carry_q <= carry_d;
      pc_q    <= pc_d;
      iflag_q <= iflag_d;
      out_q   <= out_d;
`ifdef MCPU_LINK_EN
      link_q  <= link_d;
`endif
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcpu_param_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcpu_param_core
// Description : Self-checking bench for mcpu_param_core. Two instances
//               (REG_DEPTH=8 and REG_DEPTH=4) run the same instruction
//               stream and are compared with an arithmetic reference model.
//               Honours MCPU_LINK_EN for the JSR/RET expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcpu_param_core;

  localparam int D_MOD  = 256;
  localparam int PC_MOD = 64;

  logic       clk;
  logic       rst;
  logic [5:0] inst_in;
  logic [7:0] cpu_out8;
  logic [7:0] cpu_out4;

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = depth-8 instance, 1 = depth-4 instance
  int m_depth [2];
  int m_accu  [2];
  int m_carry [2];
  int m_pc    [2];
  int m_iflag [2];
  int m_out   [2];
  int m_link  [2];
  int m_regs  [2][8];

  logic [7:0] last_pc  [2];
  logic [7:0] last_out [2];

  mcpu_param_core #(.DATA_W(8), .PC_W(6), .REG_DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .inst_in(inst_in), .cpu_out(cpu_out8)
  );

  mcpu_param_core #(.DATA_W(8), .PC_W(6), .REG_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .inst_in(inst_in), .cpu_out(cpu_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] dut_out(input int d);
    return (d == 0) ? cpu_out8 : cpu_out4;
  endfunction

  task automatic chk1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int d = 0; d < 2; d++) begin
      m_accu[d] = 0; m_carry[d] = 0; m_pc[d] = 0;
      m_iflag[d] = 0; m_out[d] = 0; m_link[d] = 0;
      for (int r = 0; r < 8; r++) m_regs[d][r] = 0;
    end
  endtask

  task automatic mdl_exec(input int d, input logic [5:0] ins);
    int imm, simm, r, rv, nxt, s, c, ldi;
    imm  = int'(ins[3:0]);
    simm = (imm >= 8) ? imm - 16 : imm;
    r    = int'(ins[2:0]);
    rv   = (r < m_depth[d]) ? m_regs[d][r] : 0;
    nxt  = (m_pc[d] + 1) % PC_MOD;
    ldi  = 0;
    if (ins[5:4] == 2'b00) begin
      if (m_carry[d] == 0) nxt = (m_pc[d] + simm + PC_MOD) % PC_MOD;
      m_carry[d] = 0;
    end else if (ins[5:4] == 2'b01) begin
      m_accu[d] = (m_iflag[d] != 0) ? (m_accu[d] * 16 + imm) % D_MOD : (simm + D_MOD) % D_MOD;
      ldi = 1;
    end else begin
      case (ins[5:3])
        3'b100: begin
          s = m_accu[d] + rv;
          m_carry[d] = s / D_MOD;
          m_accu[d]  = s % D_MOD;
        end
        3'b101: if (r < m_depth[d]) m_regs[d][r] = m_accu[d];
        3'b110: m_accu[d] = rv;
        default: begin
          case (ins[2:0])
            3'd0: m_accu[d] = D_MOD - 1 - m_accu[d];
            3'd1: m_out[d] = m_accu[d];
            3'd2: nxt = m_accu[d] % PC_MOD;
`ifdef MCPU_LINK_EN
            3'd3: begin
              m_link[d] = (m_pc[d] + 1) % PC_MOD;
              nxt = m_accu[d] % PC_MOD;
            end
            3'd4: nxt = m_link[d];
`endif
            3'd5: begin
              c = m_carry[d];
              m_carry[d] = m_accu[d] % 2;
              m_accu[d]  = m_accu[d] / 2 + c * (D_MOD / 2);
            end
            default: ;
          endcase
        end
      endcase
    end
    m_pc[d]    = nxt;
    m_iflag[d] = ldi;
  endtask

  // Entered and left with clk=0 (just after a falling edge)
  task automatic step(input logic [5:0] ins);
    inst_in = ins;
    @(posedge clk);
    for (int d = 0; d < 2; d++) mdl_exec(d, ins);
    #1;
    for (int d = 0; d < 2; d++) begin
      last_pc[d] = dut_out(d);
      chk1($sformatf("pc d%0d ins=%06b", d, ins), last_pc[d], 8'(m_pc[d]));
    end
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      last_out[d] = dut_out(d);
      chk1($sformatf("out d%0d ins=%06b", d, ins), last_out[d], 8'(m_out[d]));
    end
  endtask

  // Reset pulse starting in the clk=0 phase and spanning one rising edge
  task automatic do_reset();
    rst = 1'b0;
    mdl_reset();
    #1;
    for (int d = 0; d < 2; d++) chk1($sformatf("rst clk0 d%0d", d), dut_out(d), 8'h00);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk1($sformatf("rst clk1 d%0d", d), dut_out(d), 8'h00);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int p;
    m_depth[0] = 8;
    m_depth[1] = 4;
    rst     = 1'b0;
    inst_in = 6'b000000;
    #1;
    do_reset();

    // LDI 5 then OUT
    step(6'b010101);
    step(6'b111001);
    for (int d = 0; d < 2; d++) begin
      chk1("ldi_out pc", last_pc[d], 8'h02);
      chk1("ldi_out out", last_out[d], 8'h05);
    end

    // Chained LDI, then iflag cleared by an intervening instruction
    step(6'b011111);
    step(6'b010011);
    step(6'b111001);
    for (int d = 0; d < 2; d++) chk1("ldi_chain", last_out[d], 8'hF3);
    step(6'b000000);
    step(6'b010011);
    step(6'b111001);
    for (int d = 0; d < 2; d++) chk1("ldi_fresh", last_out[d], 8'h03);

    // ADD carry out, then BCC with carry set and clear
    step(6'b011111);
    step(6'b101000);
    step(6'b100000);
    step(6'b111001);
    for (int d = 0; d < 2; d++) chk1("add_sum", last_out[d], 8'hFE);
    p = m_pc[0];
    step(6'b000010);
    for (int d = 0; d < 2; d++) chk1("bcc_taken_carry", last_pc[d], 8'((p + 1) % PC_MOD));
    step(6'b000010);
    for (int d = 0; d < 2; d++) chk1("bcc_branch", last_pc[d], 8'((p + 3) % PC_MOD));

    // JSR at pc=3 with accu=0x10, then RET
    do_reset();
    step(6'b010001);
    step(6'b010000);
    step(6'b111110);
    for (int d = 0; d < 2; d++) chk1("pre_jsr pc", last_pc[d], 8'h03);
    step(6'b111011);
`ifdef MCPU_LINK_EN
    for (int d = 0; d < 2; d++) chk1("jsr pc", last_pc[d], 8'h10);
    step(6'b111100);
    for (int d = 0; d < 2; d++) chk1("ret pc", last_pc[d], 8'h04);
`else
    for (int d = 0; d < 2; d++) chk1("jsr nop pc", last_pc[d], 8'h04);
    step(6'b111100);
    for (int d = 0; d < 2; d++) chk1("ret nop pc", last_pc[d], 8'h05);
`endif

    // pc wrap forwards and backwards, out-of-range register access
    do_reset();
    step(6'b011111);
    step(6'b111010);
    for (int d = 0; d < 2; d++) chk1("jmpa 63", last_pc[d], 8'h3F);
    step(6'b111111);
    for (int d = 0; d < 2; d++) chk1("wrap fwd", last_pc[d], 8'h00);
    step(6'b111110);
    step(6'b111110);
    step(6'b001000);
    for (int d = 0; d < 2; d++) chk1("wrap back", last_pc[d], 8'h3A);
    step(6'b101011);
    step(6'b101101);
    step(6'b110101);
    step(6'b111001);
    chk1("lda r5 d8", last_out[0], 8'hFF);
    chk1("lda r5 d4", last_out[1], 8'h00);
    step(6'b110011);
    step(6'b111001);
    for (int d = 0; d < 2; d++) chk1("lda r3", last_out[d], 8'hFF);

    // Reset mid-program with an OUT pending, then resume
    step(6'b010111);
    step(6'b111001);
    inst_in = 6'b111001;
    do_reset();
    step(6'b010001);
    step(6'b111001);
    for (int d = 0; d < 2; d++) chk1("post_rst out", last_out[d], 8'h01);

    // Random instruction stream with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      step(6'($urandom_range(0, 63)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
